// File: rtl/fft_sample_ram.sv
// Complex-sample RAM shared between the host and the FFT core, with an
// ownership handshake, bit-reversed host write addressing and a frame load counter.
module fft_sample_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int BITREV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [2*DATA_W-1:0]   host_wdata,
  output logic [2*DATA_W-1:0]   host_rdata,
  output logic                  host_rvalid,
  output logic                  host_err,
  output logic                  frame_full,
  input  logic                  core_req,
  input  logic                  core_rel,
  output logic                  core_gnt,
  input  logic                  core_rd_en,
  input  logic [ADDR_W-1:0]     core_rd_addr,
  output logic [2*DATA_W-1:0]   core_rd_data,
  output logic                  core_rd_valid,
  input  logic                  core_wr_en,
  input  logic [ADDR_W-1:0]     core_wr_addr,
  input  logic [2*DATA_W-1:0]   core_wr_data
);
  localparam int W     = 2 * DATA_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {HOST, CORE} state_t;
  state_t state, state_nx;

  logic [W-1:0]      mem [DEPTH];
  logic              host_own, host_wr_ok, host_rd_ok, core_wr_ok, core_rd_ok, grant_edge;
  logic [ADDR_W-1:0] rev_addr, host_waddr, wr_addr, rd_addr;
  logic [W-1:0]      wr_data, rd_word;
  logic              wr_en;
  logic [ADDR_W:0]   load_cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HOST;
    else        state <= state_nx;

  // Release wins over a concurrent request; a held request re-grants next edge.
  always_comb begin
    state_nx = state;
    case (state)
      HOST: if (core_req) state_nx = CORE;
      CORE: if (core_rel) state_nx = HOST;
      default: state_nx = HOST;
    endcase
  end

  assign core_gnt   = (state == CORE);
  assign host_own   = (state == HOST);
  assign host_wr_ok = host_own && host_wr;
  assign host_rd_ok = host_own && host_rd;
  assign core_wr_ok = !host_own && core_wr_en;
  assign core_rd_ok = !host_own && core_rd_en;
  assign grant_edge = host_own && core_req;

  always_comb begin
    rev_addr = '0;
    for (int i = 0; i < ADDR_W; i++) rev_addr[i] = host_addr[ADDR_W-1-i];
  end
  assign host_waddr = (BITREV != 0) ? rev_addr : host_addr;

  // Owners are exclusive, so a single write port and a single read port suffice.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = host_waddr;
    wr_data = host_wdata;
    if (host_wr_ok) begin
      wr_en = 1'b1;
    end else if (core_wr_ok) begin
      wr_en   = 1'b1;
      wr_addr = core_wr_addr;
      wr_data = core_wr_data;
    end
  end

  assign rd_addr = host_own ? host_addr : core_rd_addr;
  assign rd_word = mem[rd_addr];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata    <= '0;
      host_rvalid   <= 1'b0;
      core_rd_data  <= '0;
      core_rd_valid <= 1'b0;
      host_err      <= 1'b0;
    end else begin
      host_rvalid   <= host_rd_ok;
      core_rd_valid <= core_rd_ok;
      if (host_rd_ok) host_rdata   <= rd_word;
      if (core_rd_ok) core_rd_data <= rd_word;
      if (!host_own && (host_wr || host_rd)) host_err <= 1'b1;
    end
  end

  // Counts writes, not distinct addresses; a grant starts a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            load_cnt <= '0;
    else if (grant_edge)                   load_cnt <= '0;
    else if (host_wr_ok && load_cnt != FULL) load_cnt <= load_cnt + 1'b1;
  end

  assign frame_full = (load_cnt == FULL);
endmodule

// File: tb/tb_fft_sample_ram.sv
// Directed bench for fft_sample_ram with ADDR_W=3, BITREV=1.
module tb_fft_sample_ram;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk, rst_n;
  logic          host_wr, host_rd;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata, host_rdata;
  logic          host_rvalid, host_err, frame_full;
  logic          core_req, core_rel, core_gnt;
  logic          core_rd_en, core_wr_en, core_rd_valid;
  logic [AW-1:0] core_rd_addr, core_wr_addr;
  logic [31:0]   core_rd_data, core_wr_data;

  int n_chk = 0, n_pass = 0;

  fft_sample_ram #(.DATA_W(DW), .ADDR_W(AW), .BITREV(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_err(host_err), .frame_full(frame_full),
    .core_req(core_req), .core_rel(core_rel), .core_gnt(core_gnt),
    .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
    .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_full;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_wr = 0; host_rd = 0; core_req = 0; core_rel = 0;
    core_rd_en = 0; core_wr_en = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    host_addr = '0; host_wdata = '0;
    core_rd_addr = '0; core_wr_addr = '0; core_wr_data = '0;

    // Host address a lands at bitrev(a): 1<->4, 3<->6, 0,2,5,7 fixed.
    vt[0]  = '{1'b1, 1'b0, 3'd1, 32'hAAAA5555, 1'b0, 32'h00000000, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 3'd4, 32'h10000004, 1'b1, 32'hAAAA5555, 1'b0}; // wr 4 -> mem[1], rd mem[4]
    vt[2]  = '{1'b1, 1'b0, 3'd0, 32'h10000000, 1'b0, 32'hAAAA5555, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 3'd2, 32'h10000002, 1'b0, 32'hAAAA5555, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'd3, 32'h10000003, 1'b0, 32'hAAAA5555, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 3'd5, 32'h10000005, 1'b0, 32'hAAAA5555, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'd6, 32'h10000006, 1'b0, 32'hAAAA5555, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'd7, 32'h10000007, 1'b0, 32'hAAAA5555, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 3'd1, 32'h0,        1'b1, 32'h10000004, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 3'd6, 32'h0,        1'b1, 32'h10000003, 1'b1};
    vt[10] = '{1'b1, 1'b1, 3'd3, 32'h00000055, 1'b1, 32'h10000006, 1'b1}; // wr 3 -> mem[6]
    vt[11] = '{1'b0, 1'b1, 3'd6, 32'h0,        1'b1, 32'h00000055, 1'b1};

    #12;
    check("rst_gnt", {31'b0, core_gnt}, 0);
    check("rst_hvalid", {31'b0, host_rvalid}, 0);
    check("rst_cvalid", {31'b0, core_rd_valid}, 0);
    check("rst_hrdata", host_rdata, 0);
    check("rst_crdata", core_rd_data, 0);
    check("rst_err", {31'b0, host_err}, 0);
    check("rst_full", {31'b0, frame_full}, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    for (int i = 0; i < 12; i++) begin
      host_wr = vt[i].wr; host_rd = vt[i].rd;
      host_addr = vt[i].addr; host_wdata = vt[i].wdata;
      step();
      check($sformatf("vec%0d_rvalid", i), {31'b0, host_rvalid}, {31'b0, vt[i].exp_rvalid});
      check($sformatf("vec%0d_rdata", i), host_rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d_full", i), {31'b0, frame_full}, {31'b0, vt[i].exp_full});
    end
    idle();

    // Core strobes are ignored while the host owns the memory.
    core_wr_en = 1; core_wr_addr = 3'd7; core_wr_data = 32'hBAD0BAD0;
    core_rd_en = 1; core_rd_addr = 3'd7;
    step(); idle();
    check("host_own_core_rvalid", {31'b0, core_rd_valid}, 0);
    host_rd = 1; host_addr = 3'd7;
    step(); idle();
    check("host_own_no_core_wr", host_rdata, 32'h10000007);

    // Grant clears the frame counter.
    core_req = 1;
    step(); core_req = 0;
    check("grant_gnt", {31'b0, core_gnt}, 1);
    check("grant_full", {31'b0, frame_full}, 0);

    // Read-during-write returns old data.
    core_wr_en = 1; core_wr_addr = 3'd2; core_wr_data = 32'h12345678;
    core_rd_en = 1; core_rd_addr = 3'd2;
    step(); core_wr_en = 0;
    check("rdw_valid", {31'b0, core_rd_valid}, 1);
    check("rdw_old", core_rd_data, 32'h10000002);
    step(); core_rd_en = 0;
    check("rdw_new", core_rd_data, 32'h12345678);
    step();
    check("core_pulse_drop", {31'b0, core_rd_valid}, 0);
    check("core_rdata_hold", core_rd_data, 32'h12345678);

    // Host access while core owns: ignored, sticky error.
    host_wr = 1; host_addr = 3'd0; host_wdata = 32'hDEADBEEF;
    step(); idle();
    check("core_own_err", {31'b0, host_err}, 1);
    check("core_own_no_rvalid", {31'b0, host_rvalid}, 0);
    core_rd_en = 1; core_rd_addr = 3'd0;
    step(); idle();
    check("core_own_mem_kept", core_rd_data, 32'h10000000);

    core_rel = 1;
    step(); idle();
    check("rel_gnt", {31'b0, core_gnt}, 0);
    host_rd = 1; host_addr = 3'd0;
    step(); idle();
    check("rel_err_sticky", {31'b0, host_err}, 1);
    check("rel_host_rvalid", {31'b0, host_rvalid}, 1);
    check("rel_host_rdata", host_rdata, 32'h10000000);

    // Release beats a concurrent request; held request re-grants.
    core_req = 1;
    step();
    check("regrant_gnt1", {31'b0, core_gnt}, 1);
    core_rel = 1;
    step(); core_rel = 0;
    check("regrant_gnt0", {31'b0, core_gnt}, 0);
    step(); core_req = 0;
    check("regrant_gnt2", {31'b0, core_gnt}, 1);

    // Async reset right after a core read strobe.
    core_rd_en = 1; core_rd_addr = 3'd1;
    step(); core_rd_en = 0;
    check("pre_rst_cvalid", {31'b0, core_rd_valid}, 1);
    rst_n = 0;
    #1;
    check("mid_rst_cvalid", {31'b0, core_rd_valid}, 0);
    check("mid_rst_gnt", {31'b0, core_gnt}, 0);
    check("mid_rst_full", {31'b0, frame_full}, 0);
    check("mid_rst_err", {31'b0, host_err}, 0);
    check("mid_rst_crdata", core_rd_data, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fft_sample_ram.md
# fft_sample_ram

Parametrised complex-sample memory shared between the host (AXI-lite side) and the FFT butterfly core. It replaces the single-mode RAM with three capabilities: an explicit ownership handshake, optional bit-reversed addressing on host writes (DIT input ordering), and a load counter that reports when a full frame has been written. It has one read port and one write port, and in-place butterfly passes run on the core side.

## Interface
Parameters:
- DATA_W, 16, width of one real or imaginary component; a memory word is 2*DATA_W bits, {re, im}.
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words.
- BITREV, 1, when 1 host write addresses are bit-reversed before storage; when 0 they are used as-is.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- host_wr  in  1  host write strobe.
- host_rd  in  1  host read strobe.
- host_addr  in  ADDR_W  host address, shared by read and write.
- host_wdata  in  2*DATA_W  host write data.
- host_rdata  out  2*DATA_W  host read data, registered.
- host_rvalid  out  1  host_rdata valid, one-cycle pulse.
- host_err  out  1  sticky flag: a host access was attempted while the core owned the memory.
- frame_full  out  1  DEPTH host writes have been accepted since the last grant.
- core_req  in  1  core requests ownership; level signal.
- core_rel  in  1  core releases ownership; one-cycle pulse.
- core_gnt  out  1  core owns the memory.
- core_rd_en  in  1  core read strobe.
- core_rd_addr  in  ADDR_W  core read address.
- core_rd_data  out  2*DATA_W  core read data, registered.
- core_rd_valid  out  1  core_rd_data valid, one-cycle pulse.
- core_wr_en  in  1  core write strobe.
- core_wr_addr  in  ADDR_W  core write address.
- core_wr_data  in  2*DATA_W  core write data.

## Operation
- Ownership FSM has two states, HOST and CORE; core_gnt = (state == CORE).
- HOST -> CORE: core_req high at a clock edge.
- CORE -> HOST: core_rel high at a clock edge.
- core_rel has priority over core_req when both are high in CORE. A still-high core_req re-grants from the following edge.
- HOST state, host side:
  - host_wr writes host_wdata to bitrev(host_addr) when BITREV=1, else to host_addr.
  - host_rd reads the raw host_addr; reads are never reversed.
  - host_wr and host_rd may be asserted in the same cycle.
- HOST state, core side: core_rd_en and core_wr_en are ignored. No write occurs and core_rd_valid stays 0.
- CORE state, core side: core_rd_en and core_wr_en operate independently and may be asserted in the same cycle.
- CORE state, host side: host_wr and host_rd are ignored and set host_err. host_err clears only on reset.
- Ownership is decided by the state register value at the edge. A host access in the same cycle as the HOST -> CORE edge is performed.
- load_cnt is ADDR_W+1 bits wide:
  - it increments on each accepted host_wr and saturates at DEPTH;
  - frame_full = (load_cnt == DEPTH);
  - it clears on the HOST -> CORE transition.
- Rewrites to the same address still count, so frame_full reports the number of writes, not address coverage.
- Read-during-write to the same address, from either owner, returns the old data.
- Memory contents are not reset.

## Timing
- Read latency is 1 cycle. A strobe at edge N produces rdata and rvalid after edge N, both held for one cycle. rdata holds its last value when rvalid is 0.
- Write latency: data is visible to a read issued on the next edge.
- Grant latency: core_req high before edge N gives core_gnt high after edge N.
- Release latency: core_rel before edge N gives core_gnt low after edge N. Host access is legal from edge N+1.
- Reset values:
  - state HOST, core_gnt 0;
  - host_rvalid 0, core_rd_valid 0;
  - host_rdata 0, core_rd_data 0;
  - host_err 0, load_cnt 0, frame_full 0.
- Reset asserted mid-frame or mid-compute forces these values immediately. Any in-flight read pulse is dropped.

## Test plan
- ADDR_W=3, BITREV=1. Host writes 0xAAAA5555 to address 1, then reads address 4 -> host_rvalid one cycle later with 0xAAAA5555. A read of address 1 returns the prior content.
- ADDR_W=3. Eight host writes -> frame_full rises after the 8th accepting edge. Raise core_req -> core_gnt=1 the next cycle and frame_full=0.
- In CORE, core_wr_en at address 2 with 0x12345678 and core_rd_en at address 2 in the same cycle -> old data returned. A read on the next cycle returns 0x12345678.
- In CORE, host_wr to address 0 -> memory is unchanged and host_err=1. After a core_rel pulse, host_err remains 1 and a host read works with host_rvalid=1.
- In CORE, core_rel and core_req asserted together -> core_gnt=0 for one cycle, then 1 again.
- Assert rst_n low in the cycle after a core read strobe -> core_rd_valid=0 immediately, core_gnt=0 and frame_full=0.
